// File: rtl/mac_acc_pkg.sv
// Shared types and constants for the BF16/INT8 dot-product accumulator.
package mac_acc_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 7;
    localparam int EXT_W   = 11;  // {hidden, mantissa, guard, round, sticky}
    localparam int ENTRY_W = 18;  // {last, int8, data}

    localparam logic [EXP_W-1:0] BF16_INF_EXP = 8'hFF;
    localparam logic [15:0]      INT16_MAX    = 16'h7FFF;
    localparam logic [15:0]      INT16_MIN    = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_I8ADD,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_EMIT
    } state_t;

    typedef struct packed {
        logic        last;
        logic        int8;
        logic [15:0] data;
    } entry_t;

    // Right shift of an extended magnitude; every bit shifted out ORs into sticky.
    function automatic logic [EXT_W-1:0] shr_sticky(input logic [EXT_W-1:0] v,
                                                    input logic [3:0]       sh);
        logic [EXT_W-1:0] shifted;
        logic [EXT_W-1:0] mask;
        shifted    = v >> sh;
        mask       = ({{(EXT_W-1){1'b0}}, 1'b1} << sh) - {{(EXT_W-1){1'b0}}, 1'b1};
        shr_sticky = {shifted[EXT_W-1:1], shifted[0] | (|(v & mask))};
    endfunction

endpackage

// File: rtl/prod_fifo.sv
// Synchronous product FIFO; a write while full is dropped unless a pop frees a slot.
module prod_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset discards every buffered entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mac_accumulator.sv
// Running dot-product accumulator fed by the BF16/INT8 multiplier product stream.
module mac_accumulator
    import mac_acc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_prod,
    input  logic        i_vld,
    input  logic        int8_ip,
    input  logic        i_last,
    output logic [15:0] o_acc,
    output logic        o_acc_vld,
    output logic        o_busy,
    output logic        o_ovf,
    output logic        o_mode_err
);

    state_t state, state_nxt;

    entry_t wr_entry, rd_entry;
    logic   fifo_full, fifo_empty, pop;

    logic [15:0] acc;
    logic [15:0] cur_data;
    logic        cur_last;
    logic        mode_set, mode_int8, mismatch;

    logic [EXT_W-1:0]  a_mag, p_mag, r_mag;
    logic              a_sgn, p_sgn, r_sgn;
    logic signed [9:0] e_r;

    assign wr_entry = '{last: i_last, int8: int8_ip, data: i_prod};
    assign mismatch = mode_set && (rd_entry.int8 != mode_int8);

    prod_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_data(wr_entry),
        .wr_en  (i_vld),
        .rd_en  (pop),
        .rd_data(rd_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // INT8 saturating add
    logic [16:0] i8_sum;
    logic [15:0] i8_res;
    assign i8_sum = {acc[15], acc} + {{9{cur_data[7]}}, cur_data[7:0]};
    assign i8_res = (i8_sum[16] != i8_sum[15]) ? (i8_sum[16] ? INT16_MIN : INT16_MAX)
                                               : i8_sum[15:0];

    // BF16 operand classification and alignment
    logic [EXP_W-1:0] p_exp, a_exp, exp_diff, al_exp;
    logic [EXT_W-1:0] p_ext, a_ext, al_a, al_p;
    logic [3:0]       sh_amt;
    logic             p_zero, a_zero, any_inf, p_big, shortcut;
    logic [15:0]      short_res;

    assign p_exp    = cur_data[14:7];
    assign a_exp    = acc[14:7];
    assign p_zero   = (p_exp == '0);
    assign a_zero   = (a_exp == '0);
    assign any_inf  = (p_exp == BF16_INF_EXP) || (a_exp == BF16_INF_EXP);
    assign shortcut = p_zero || a_zero || any_inf;
    assign p_ext    = {1'b1, cur_data[MAN_W-1:0], 3'b000};
    assign a_ext    = {1'b1, acc[MAN_W-1:0], 3'b000};
    assign p_big    = (p_exp > a_exp);
    assign exp_diff = p_big ? (p_exp - a_exp) : (a_exp - p_exp);
    assign sh_amt   = (exp_diff > 8'd11) ? 4'd11 : exp_diff[3:0];
    assign al_a     = p_big ? shr_sticky(a_ext, sh_amt) : a_ext;
    assign al_p     = p_big ? p_ext : shr_sticky(p_ext, sh_amt);
    assign al_exp   = p_big ? p_exp : a_exp;

    // Shortcut result priority: zero operand first, then infinity (existing inf is kept)
    always_comb begin
        short_res = acc;
        if (p_zero)                     short_res = acc;
        else if (a_zero)                short_res = cur_data;
        else if (a_exp == BF16_INF_EXP) short_res = acc;
        else                            short_res = {cur_data[15], BF16_INF_EXP, 7'h00};
    end

    // Signed-magnitude add of the aligned operands
    logic [11:0]       sum12;
    logic              add_sgn, add_zero;
    logic [EXT_W-1:0]  add_mag;
    logic signed [9:0] add_exp;

    always_comb begin
        sum12   = '0;
        add_sgn = a_sgn;
        if (a_sgn == p_sgn) begin
            sum12 = {1'b0, a_mag} + {1'b0, p_mag};
        end else if (a_mag >= p_mag) begin
            sum12 = {1'b0, a_mag - p_mag};
        end else begin
            sum12   = {1'b0, p_mag - a_mag};
            add_sgn = p_sgn;
        end
    end

    assign add_zero = (sum12 == '0);
    assign add_mag  = sum12[11] ? {sum12[11:2], sum12[1] | sum12[0]} : sum12[10:0];
    assign add_exp  = sum12[11] ? e_r + 10'sd1 : e_r;

    // Round to nearest even and range clamp
    logic              rup;
    logic [8:0]        mant9;
    logic signed [9:0] rnd_exp;
    logic [MAN_W-1:0]  rnd_man;
    logic [15:0]       rnd_res;

    assign rup     = r_mag[2] && (r_mag[1] || r_mag[0] || r_mag[3]);
    assign mant9   = {1'b0, r_mag[10:3]} + {8'd0, rup};
    assign rnd_exp = mant9[8] ? e_r + 10'sd1 : e_r;
    assign rnd_man = mant9[8] ? mant9[7:1] : mant9[6:0];

    always_comb begin
        rnd_res = {r_sgn, rnd_exp[7:0], rnd_man};
        if (rnd_exp >= 10'sd255)    rnd_res = {r_sgn, BF16_INF_EXP, 7'h00};
        else if (rnd_exp <= 10'sd0) rnd_res = {r_sgn, 15'h0000};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (mismatch)           state_nxt = rd_entry.last ? ST_EMIT : ST_IDLE;
                    else if (rd_entry.int8) state_nxt = ST_I8ADD;
                    else                    state_nxt = ST_ALIGN;
                end
            end
            ST_I8ADD: state_nxt = cur_last ? ST_EMIT : ST_IDLE;
            ST_ALIGN: begin
                if (shortcut) state_nxt = cur_last ? ST_EMIT : ST_IDLE;
                else          state_nxt = ST_ADD;
            end
            ST_ADD: begin
                if (add_zero)        state_nxt = cur_last ? ST_EMIT : ST_IDLE;
                else if (add_mag[10]) state_nxt = ST_ROUND;
                else                 state_nxt = ST_NORM;
            end
            ST_NORM:  state_nxt = r_mag[9] ? ST_ROUND : ST_NORM;
            ST_ROUND: state_nxt = cur_last ? ST_EMIT : ST_IDLE;
            ST_EMIT:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop and busy flag
    always_comb begin
        pop    = (state == ST_IDLE) && !fifo_empty;
        o_busy = (state != ST_IDLE) || !fifo_empty;
    end

    // Datapath registers, result output and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc        <= '0;
            cur_data   <= '0;
            cur_last   <= 1'b0;
            mode_set   <= 1'b0;
            mode_int8  <= 1'b0;
            a_mag      <= '0;
            p_mag      <= '0;
            r_mag      <= '0;
            a_sgn      <= 1'b0;
            p_sgn      <= 1'b0;
            r_sgn      <= 1'b0;
            e_r        <= '0;
            o_acc      <= '0;
            o_acc_vld  <= 1'b0;
            o_ovf      <= 1'b0;
            o_mode_err <= 1'b0;
        end else begin
            o_acc_vld <= 1'b0;
            if (i_vld && fifo_full && !pop) o_ovf <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cur_data <= rd_entry.data;
                        cur_last <= rd_entry.last;
                        if (mismatch) begin
                            o_mode_err <= 1'b1;
                        end else if (!mode_set) begin
                            mode_set  <= 1'b1;
                            mode_int8 <= rd_entry.int8;
                        end
                    end
                end
                ST_I8ADD: acc <= i8_res;
                ST_ALIGN: begin
                    if (shortcut) begin
                        acc <= short_res;
                    end else begin
                        a_mag <= al_a;
                        p_mag <= al_p;
                        a_sgn <= acc[15];
                        p_sgn <= cur_data[15];
                        e_r   <= $signed({2'b00, al_exp});
                    end
                end
                ST_ADD: begin
                    if (add_zero) begin
                        acc <= '0;
                    end else begin
                        r_mag <= add_mag;
                        r_sgn <= add_sgn;
                        e_r   <= add_exp;
                    end
                end
                ST_NORM: begin
                    r_mag <= {r_mag[EXT_W-2:0], 1'b0};
                    e_r   <= e_r - 10'sd1;
                end
                ST_ROUND: acc <= rnd_res;
                ST_EMIT: begin
                    o_acc     <= acc;
                    o_acc_vld <= 1'b1;
                    acc       <= '0;
                    mode_set  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_prod = '0;
    logic        i_vld = 1'b0;
    logic        int8_ip = 1'b0;
    logic        i_last = 1'b0;
    logic [15:0] o_acc;
    logic        o_acc_vld;
    logic        o_busy;
    logic        o_ovf;
    logic        o_mode_err;

    int checks = 0;
    int errors = 0;

    mac_accumulator #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_prod    (i_prod),
        .i_vld     (i_vld),
        .int8_ip   (int8_ip),
        .i_last    (i_last),
        .o_acc     (o_acc),
        .o_acc_vld (o_acc_vld),
        .o_busy    (o_busy),
        .o_ovf     (o_ovf),
        .o_mode_err(o_mode_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One-cycle write into the FIFO; returns 1 time unit after the capturing edge.
    task automatic push(input logic [15:0] d, input logic i8, input logic last);
        i_prod  = d;
        int8_ip = i8;
        i_last  = last;
        i_vld   = 1'b1;
        @(posedge clk); #1;
        i_vld  = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic wait_emit(output logic [15:0] v, output bit got);
        got = 0;
        v   = '0;
        for (int i = 0; i < 300; i++) begin
            if (o_acc_vld) begin
                v   = o_acc;
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!o_busy) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_acc !== 16'h0000) begin errors++; $display("FAIL reset_acc got %h exp 0000", o_acc); end
        checks++; if (o_acc_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", o_acc_vld); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", o_ovf); end
        checks++; if (o_mode_err !== 1'b0) begin errors++; $display("FAIL reset_mode_err got %b exp 0", o_mode_err); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_bf16_add();
        logic [15:0] v;
        bit          got;
        push(16'h3F80, 1'b0, 1'b0);
        push(16'h3F80, 1'b0, 1'b1);
        wait_emit(v, got);
        checks++; if (!got) begin errors++; $display("FAIL bf16_1p1_timeout got none exp pulse"); end
        checks++; if (v !== 16'h4000) begin errors++; $display("FAIL bf16_1p1 got %h exp 4000", v); end
        @(posedge clk); #1;
        checks++; if (o_acc_vld !== 1'b0) begin errors++; $display("FAIL bf16_one_pulse got %b exp 0", o_acc_vld); end
        push(16'h3F80, 1'b0, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h3F80) begin errors++; $display("FAIL bf16_acc_cleared got %h exp 3F80", v); end
    endtask

    task automatic test_bf16_round();
        logic [15:0] a  [3] = '{16'h3F80, 16'h3F81, 16'h3F80};
        logic [15:0] b  [3] = '{16'hBF80, 16'h3B80, 16'h3B80};
        logic [15:0] ex [3] = '{16'h0000, 16'h3F82, 16'h3F80};
        logic [15:0] v;
        bit          got;
        for (int i = 0; i < 3; i++) begin
            push(a[i], 1'b0, 1'b0);
            push(b[i], 1'b0, 1'b1);
            wait_emit(v, got);
            checks++;
            if (!got || v !== ex[i]) begin
                errors++;
                $display("FAIL bf16_round_%0d got %h exp %h", i, v, ex[i]);
            end
        end
    endtask

    task automatic test_bf16_inf();
        logic [15:0] v;
        bit          got;
        push(16'h7F80, 1'b0, 1'b0);
        push(16'h3F80, 1'b0, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h7F80) begin errors++; $display("FAIL bf16_inf_keep got %h exp 7F80", v); end
        push(16'h7F00, 1'b0, 1'b0);
        push(16'h7F00, 1'b0, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h7F80) begin errors++; $display("FAIL bf16_exp_ovf got %h exp 7F80", v); end
    endtask

    task automatic test_int8();
        logic [15:0] v;
        bit          got;
        wait_idle();
        push(16'h0005, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++; if (o_acc_vld !== 1'b0) begin errors++; $display("FAIL int8_lat_e1 got %b exp 0", o_acc_vld); end
        @(posedge clk); #1;
        checks++; if (o_acc_vld !== 1'b0) begin errors++; $display("FAIL int8_lat_e2 got %b exp 0", o_acc_vld); end
        @(posedge clk); #1;
        checks++; if (o_acc_vld !== 1'b1 || o_acc !== 16'h0005) begin errors++; $display("FAIL int8_lat_e3 vld %b acc %h exp 1 0005", o_acc_vld, o_acc); end
        push(16'h00FF, 1'b1, 1'b0);
        push(16'h0003, 1'b1, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h0002) begin errors++; $display("FAIL int8_neg_add got %h exp 0002", v); end
        for (int i = 0; i < 300; i++) begin
            push(16'h007F, 1'b1, 1'b0);
            @(posedge clk); @(posedge clk); #1;
        end
        push(16'h0000, 1'b1, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h7FFF) begin errors++; $display("FAIL int8_sat_pos got %h exp 7FFF", v); end
        for (int i = 0; i < 300; i++) begin
            push(16'h0080, 1'b1, 1'b0);
            @(posedge clk); @(posedge clk); #1;
        end
        push(16'h0000, 1'b1, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h8000) begin errors++; $display("FAIL int8_sat_neg got %h exp 8000", v); end
    endtask

    task automatic test_mode_err();
        logic [15:0] v;
        bit          got;
        checks++; if (o_mode_err !== 1'b0) begin errors++; $display("FAIL mode_err_pre got %b exp 0", o_mode_err); end
        push(16'h3F80, 1'b0, 1'b0);
        push(16'h0005, 1'b1, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h3F80) begin errors++; $display("FAIL mode_err_sum got %h exp 3F80", v); end
        checks++; if (o_mode_err !== 1'b1) begin errors++; $display("FAIL mode_err_flag got %b exp 1", o_mode_err); end
    endtask

    task automatic test_overflow();
        logic [15:0] v;
        bit          got;
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", o_ovf); end
        push(16'h3F80, 1'b0, 1'b0);
        wait_idle();
        // 1.0 - 0.99609375 leaves 2^-8 and needs eight NORM cycles, so the FSM pops once during the burst
        push(16'hBF7F, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push(16'h3F80, 1'b0, 1'b0);
        push(16'h4000, 1'b0, 1'b0);
        checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", o_ovf); end
        wait_idle();
        push(16'h0000, 1'b0, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h4100) begin errors++; $display("FAIL ovf_sum got %h exp 4100", v); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        bit          got;
        wait_idle();
        push(16'h3F80, 1'b0, 1'b0);
        push(16'hBF7F, 1'b0, 1'b1);
        push(16'h4000, 1'b0, 1'b0);
        push(16'h4000, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", o_busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (o_acc !== 16'h0000) begin errors++; $display("FAIL mid_rst_acc got %h exp 0000", o_acc); end
        checks++; if (o_acc_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got %b exp 0", o_acc_vld); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", o_busy); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %b exp 0", o_ovf); end
        checks++; if (o_mode_err !== 1'b0) begin errors++; $display("FAIL mid_rst_mode_err got %b exp 0", o_mode_err); end
        push(16'h3F80, 1'b0, 1'b1);
        wait_emit(v, got);
        checks++; if (!got || v !== 16'h3F80) begin errors++; $display("FAIL mid_rst_after got %h exp 3F80", v); end
    endtask

    initial begin
        test_reset();
        test_bf16_add();
        test_bf16_round();
        test_bf16_inf();
        test_int8();
        test_mode_err();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
